// File: rtl/alu_div_seq.sv
// rtl/alu_div_seq.sv - multicycle restoring divider that borrows the datapath ALU for its subtracts
// Optional signed mode (is_signed port) is enabled by defining ALU_DIV_SIGNED_EN.
module alu_div_seq #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef ALU_DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_set,
  input  logic             alu_overflow
);

  localparam int CW = $clog2(ITERS);
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic [1:0] {IDLE, CHECK, ITER, DONE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] dvd, dvs, rem;
  logic [WIDTH-1:0] sh, rem_new, q_new, q_fin, r_fin, dz_rem;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic             rem_hi, ge;
  logic [CW-1:0]    cnt;
  logic             unused_alu_flags;

  assign unused_alu_flags = alu_set ^ alu_overflow;

  // rem_hi is the bit shifted out of the 32-bit remainder; when set the subtract must succeed.
  assign rem_hi  = rem[WIDTH-1];
  assign sh      = {rem[WIDTH-2:0], dvd[WIDTH-1]};
  assign ge      = rem_hi | ((sh[WIDTH-1] ^ dvs[WIDTH-1]) ? sh[WIDTH-1] : ~alu_result[WIDTH-1]);
  assign rem_new = ge ? alu_result : sh;
  assign q_new   = {dvd[WIDTH-2:0], ge};

`ifdef ALU_DIV_SIGNED_EN
  logic a_neg, b_neg, q_neg, r_neg;

  assign a_neg        = is_signed & dividend[WIDTH-1];
  assign b_neg        = is_signed & divisor[WIDTH-1];
  assign dividend_mag = a_neg ? -dividend : dividend;
  assign divisor_mag  = b_neg ? -divisor : divisor;
  assign q_fin        = q_neg ? -q_new : q_new;
  assign r_fin        = r_neg ? -rem_new : rem_new;
  assign dz_rem       = r_neg ? -dvd : dvd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (state == IDLE && start) begin
      q_neg <= a_neg ^ b_neg;
      r_neg <= a_neg;
    end
  end
`else
  assign dividend_mag = dividend;
  assign divisor_mag  = divisor;
  assign q_fin        = q_new;
  assign r_fin        = rem_new;
  assign dz_rem       = dvd;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = OP_ADD;
    case (state)
      IDLE: if (start) next_state = CHECK;
      CHECK: begin
        busy       = 1'b1;
        alu_a      = dvs;
        alu_op     = OP_OR;
        next_state = alu_zero ? DONE : ITER;
      end
      ITER: begin
        busy   = 1'b1;
        alu_a  = sh;
        alu_b  = dvs;
        alu_op = OP_SUB;
        if (cnt == LAST) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // dvd doubles as the quotient shift register once iterations begin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dvd         <= dividend_mag;
          dvs         <= divisor_mag;
          rem         <= '0;
          div_by_zero <= 1'b0;
        end
        CHECK: begin
          if (alu_zero) begin
            quotient    <= '1;
            remainder   <= dz_rem;
            div_by_zero <= 1'b1;
          end else begin
            cnt <= '0;
          end
        end
        ITER: begin
          rem <= rem_new;
          dvd <= q_new;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            quotient  <= q_fin;
            remainder <= r_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// tb/tb_alu_div_seq.sv - scoreboard bench for alu_div_seq with a behavioural ALU
// Signed scenarios are built when ALU_DIV_SIGNED_EN is defined.
module tb_alu_div_seq;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] dividend, divisor;
`ifdef ALU_DIV_SIGNED_EN
  logic        is_signed;
`endif
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder, alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        alu_zero, alu_set, alu_overflow;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  alu_div_seq dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
`ifdef ALU_DIV_SIGNED_EN
    .is_signed(is_signed),
`endif
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_set(alu_set), .alu_overflow(alu_overflow)
  );

  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    case (alu_op)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = ~(alu_a[31] ^ alu_b[31]) & (alu_a[31] ^ alu_result[31]);
      end
      3'b110: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a[31] ^ alu_b[31]) & (alu_a[31] ^ alu_result[31]);
      end
      3'b111: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'b0);
    alu_set  = alu_result[31];
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    exp_t e;
    logic [31:0] ma, mb, q, r;
    e.dz = 1'b0;
    if (b == 32'b0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else if (!sgn) begin
      e.q = a / b; e.r = a % b;
    end else begin
      ma = a[31] ? -a : a;
      mb = b[31] ? -b : b;
      q = ma / mb; r = ma % mb;
      e.q = (a[31] ^ b[31]) ? -q : q;
      e.r = a[31] ? -r : r;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (or after the cycle budget).
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn, input int inject_at,
                        output int lat, output int busy_n, output logic [2:0] chk_op, output logic [2:0] itr_op);
    dividend = a; divisor = b; start = 1'b1;
`ifdef ALU_DIV_SIGNED_EN
    is_signed = sgn;
`endif
    sb.push_back(model(a, b, sgn));
    busy_n = 0; chk_op = 3'bxxx; itr_op = 3'bxxx;
    @(negedge clk); start = 1'b0; lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_n++;
      if (lat == 1) chk_op = alu_op;
      if (lat == 2) itr_op = alu_op;
      if (lat == inject_at) begin dividend = 9; divisor = 3; start = 1'b1; end
      else start = 1'b0;
      @(negedge clk); lat++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (quotient !== 32'h0) begin n_err++; $display("FAIL reset_quotient: got %h want 0", quotient); end
    n_cmp++; if (remainder !== 32'h0) begin n_err++; $display("FAIL reset_remainder: got %h want 0", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    n_cmp++; if (alu_a !== 32'h0 || alu_b !== 32'h0) begin n_err++; $display("FAIL reset_alu_ab: got %h/%h want 0/0", alu_a, alu_b); end
    n_cmp++; if (alu_op !== 3'b010) begin n_err++; $display("FAIL reset_alu_op: got %b want 010", alu_op); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int lat, bn; logic [2:0] co, io; exp_t e;
    @(negedge clk);
    do_div(32'd100, 32'd7, 1'b0, 0, lat, bn, co, io);
    e = sb.pop_front();
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL basic_latency: got %0d want 34", lat); end
    n_cmp++; if (bn !== 33) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 33", bn); end
    n_cmp++; if (co !== 3'b001) begin n_err++; $display("FAIL basic_check_op: got %b want 001", co); end
    n_cmp++; if (io !== 3'b110) begin n_err++; $display("FAIL basic_iter_op: got %b want 110", io); end
    n_cmp++; if (quotient !== e.q || e.q !== 32'd14) begin n_err++; $display("FAIL basic_quotient: got %0d want 14", quotient); end
    n_cmp++; if (remainder !== e.r || e.r !== 32'd2) begin n_err++; $display("FAIL basic_remainder: got %0d want 2", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL basic_dbz: got %b want 0", div_by_zero); end
  endtask

  task automatic test_msb_divisor();
    int lat, bn; logic [2:0] co, io; exp_t e;
    @(negedge clk);
    do_div(32'hFFFFFFFF, 32'h80000000, 1'b0, 0, lat, bn, co, io);
    e = sb.pop_front();
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL msb_latency: got %0d want 34", lat); end
    n_cmp++; if (quotient !== e.q) begin n_err++; $display("FAIL msb_quotient: got %h want %h", quotient, e.q); end
    n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL msb_remainder: got %h want %h", remainder, e.r); end
  endtask

  task automatic test_div_by_zero();
    int lat, bn; logic [2:0] co, io; exp_t e;
    @(negedge clk);
    do_div(32'd1234, 32'd0, 1'b0, 0, lat, bn, co, io);
    e = sb.pop_front();
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL dbz_latency: got %0d want 2", lat); end
    n_cmp++; if (quotient !== e.q) begin n_err++; $display("FAIL dbz_quotient: got %h want %h", quotient, e.q); end
    n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL dbz_remainder: got %0d want %0d", remainder, e.r); end
    n_cmp++; if (div_by_zero !== e.dz) begin n_err++; $display("FAIL dbz_flag: got %b want %b", div_by_zero, e.dz); end
  endtask

  task automatic test_table();
    logic [31:0] ta [8];
    logic [31:0] tb [8];
    int lat, bn; logic [2:0] co, io; exp_t e;
    ta = '{32'd0, 32'd7, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'd0, 32'd0};
    tb = '{32'd5, 32'd7, 32'd9, 32'd1, 32'hFFFFFFFF, 32'h00001234, 32'd0, 32'd0};
    for (int i = 6; i < 8; i++) begin
      ta[i] = $urandom;
      tb[i] = $urandom >> $urandom_range(0, 31);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      do_div(ta[i], tb[i], 1'b0, 0, lat, bn, co, io);
      e = sb.pop_front();
      n_cmp++; if (lat !== ((tb[i] == 0) ? 2 : 34)) begin n_err++; $display("FAIL table_latency[%0d]: got %0d", i, lat); end
      n_cmp++; if (quotient !== e.q) begin n_err++; $display("FAIL table_quotient[%0d]: %h/%h got %h want %h", i, ta[i], tb[i], quotient, e.q); end
      n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL table_remainder[%0d]: %h/%h got %h want %h", i, ta[i], tb[i], remainder, e.r); end
      n_cmp++; if (div_by_zero !== e.dz) begin n_err++; $display("FAIL table_dbz[%0d]: got %b want %b", i, div_by_zero, e.dz); end
    end
  endtask

  task automatic test_start_while_busy();
    int lat, bn, d0; logic [2:0] co, io; exp_t e;
    @(negedge clk);
    d0 = done_cnt;
    do_div(32'd100, 32'd7, 1'b0, 10, lat, bn, co, io);
    e = sb.pop_front();
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL swb_latency: got %0d want 34", lat); end
    n_cmp++; if (quotient !== e.q) begin n_err++; $display("FAIL swb_quotient: got %0d want %0d", quotient, e.q); end
    n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL swb_remainder: got %0d want %0d", remainder, e.r); end
    repeat (5) @(negedge clk);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL swb_done_pulses: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_op();
    int lat, bn, d0; logic [2:0] co, io; exp_t e;
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midrst_busy_done: got %b/%b want 0/0", busy, done); end
    n_cmp++; if (quotient !== 32'h0 || remainder !== 32'h0) begin n_err++; $display("FAIL midrst_results: got %h/%h want 0/0", quotient, remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL midrst_dbz: got %b want 0", div_by_zero); end
    n_cmp++; if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 3'b010) begin n_err++; $display("FAIL midrst_alu: got %h/%h/%b want 0/0/010", alu_a, alu_b, alu_op); end
    d0 = done_cnt;
    @(negedge clk); reset = 1'b0;
    repeat (40) @(negedge clk);
    n_cmp++; if (done_cnt !== d0) begin n_err++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - d0); end
    do_div(32'd50, 32'd5, 1'b0, 0, lat, bn, co, io);
    e = sb.pop_front();
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL midrst_after_latency: got %0d want 34", lat); end
    n_cmp++; if (quotient !== e.q || remainder !== e.r) begin n_err++; $display("FAIL midrst_after_result: got %0d/%0d want %0d/%0d", quotient, remainder, e.q, e.r); end
  endtask

  task automatic test_back_to_back();
    int lat, bn; logic [2:0] co, io; exp_t e;
    @(negedge clk);
    do_div(32'd100, 32'd7, 1'b0, 0, lat, bn, co, io);
    e = sb.pop_front();
    n_cmp++; if (quotient !== e.q) begin n_err++; $display("FAIL b2b_first_quotient: got %0d want %0d", quotient, e.q); end
    dividend = 32'd20; divisor = 32'd4; start = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_start_in_done: busy got %b want 0", busy); end
    do_div(32'd20, 32'd4, 1'b0, 0, lat, bn, co, io);
    e = sb.pop_front();
    n_cmp++; if (lat !== 34) begin n_err++; $display("FAIL b2b_latency: got %0d want 34", lat); end
    n_cmp++; if (quotient !== e.q || remainder !== e.r) begin n_err++; $display("FAIL b2b_result: got %0d/%0d want %0d/%0d", quotient, remainder, e.q, e.r); end
  endtask

`ifdef ALU_DIV_SIGNED_EN
  task automatic test_signed();
    logic [31:0] sa [3];
    logic [31:0] sd [3];
    int lat, bn; logic [2:0] co, io; exp_t e;
    sa = '{32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFFB};
    sd = '{32'd2, 32'hFFFFFFFF, 32'd0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      do_div(sa[i], sd[i], 1'b1, 0, lat, bn, co, io);
      e = sb.pop_front();
      n_cmp++; if (lat !== ((sd[i] == 0) ? 2 : 34)) begin n_err++; $display("FAIL signed_latency[%0d]: got %0d", i, lat); end
      n_cmp++; if (quotient !== e.q) begin n_err++; $display("FAIL signed_quotient[%0d]: got %h want %h", i, quotient, e.q); end
      n_cmp++; if (remainder !== e.r) begin n_err++; $display("FAIL signed_remainder[%0d]: got %h want %h", i, remainder, e.r); end
    end
    is_signed = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
`ifdef ALU_DIV_SIGNED_EN
    is_signed = 1'b0;
`endif
    test_reset();
    test_basic();
    test_msb_divisor();
    test_div_by_zero();
    test_table();
    test_start_while_busy();
    test_reset_mid_op();
    test_back_to_back();
`ifdef ALU_DIV_SIGNED_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
